// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, load/store
// size encodings and the access-length helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Encoding 3 falls through to a full word; half is clamped for byte-wide words.
    function automatic int unsigned access_len(input logic [1:0] size, input int unsigned nb);
        case (size)
            SIZE_BYTE: return 1;
            SIZE_HALF: return (nb < 2) ? nb : 2;
            default:   return nb;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_asm.sv
// Shift-assembles little-endian read bytes into a word; word_o is the fully
// aligned, zero-extended result including the byte on byte_i this cycle.
module mem_byte_asm #(
    parameter int DATA_W = 32,
    parameter int LW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    input  logic [LW-1:0]     len_i,
    output logic [DATA_W-1:0] word_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] word_q;
    logic [DATA_W+7:0] cat;
    logic [DATA_W-1:0] shifted;
    logic [LW-1:0]     pad;

    // New bytes enter at the top, so after N shifts byte 0 sits N bytes below the MSB.
    assign cat     = {byte_i, word_q};
    assign shifted = cat[DATA_W+7:8];
    assign pad     = LW'(NB) - len_i;
    assign word_o  = shifted >> {pad, 3'b000};

    always_ff @(posedge clk) begin
        if (rst)          word_q <= '0;
        else if (shift_i) word_q <= shifted;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto a byte-wide RAM
// with one cycle of read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(NB + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, lane_sh;
    logic [DATA_W-1:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d, asm_word;
    logic              if_valid_q, if_valid_d, ls_done_q, ls_done_d;
    logic              asm_shift;

    mem_byte_asm #(.DATA_W(DATA_W), .LW(CW)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .shift_i (asm_shift),
        .byte_i  (ram_din),
        .len_i   (len_q),
        .word_o  (asm_word)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // NOTE: every *_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_valid_d = 1'b0;
        ls_done_d  = 1'b0;
        asm_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                // A port whose completion pulse is showing still holds its request; skip it.
                if (ls_req && !ls_done_q) begin
                    state_d = ls_we ? LS_WR : LS_RD;
                    cnt_d   = '0;
                    len_d   = CW'(access_len(ls_size, NB));
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                end else if (if_req && !if_valid_q) begin
                    state_d = IF_RD;
                    cnt_d   = '0;
                    len_d   = CW'(NB);
                    addr_d  = if_addr;
                end
            end
            IF_RD, LS_RD: begin
                if (state_q == IF_RD && if_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // ram_din carries byte cnt-1 because the RAM answers one cycle late.
                    asm_shift = (cnt_q != '0);
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (state_q == IF_RD) begin
                            if_valid_d = 1'b1;
                            if_data_d  = asm_word;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = asm_word;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            LS_WR: begin
                if (cnt_inc == len_q) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    ls_done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            if_valid_q <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            if_valid_q <= if_valid_d;
            ls_done_q  <= ls_done_d;
        end
    end

    assign lane_sh  = wdata_q >> {cnt_q, 3'b000};
    assign ram_wr   = (state_q == LS_WR);
    assign ram_dout = ram_wr ? lane_sh[7:0] : 8'h00;
    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign if_data  = if_data_q;
    assign if_valid = if_valid_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_done  = ls_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model with one-cycle read latency,
// expected fetch/load results and RAM writes queued at stimulus time.
module tb_mem_ctrl;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              clk, rst;
    logic              if_req, if_flush, if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              ls_req, ls_we, ls_done;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata, ls_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr, busy;
    logic [7:0]        ram_dout, ram_din;

    logic [7:0]        mem [131072];
    logic [31:0]       fq[$];
    logic [32:0]       lq[$];
    logic [24:0]       wq[$];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_data  (if_data),
        .if_valid (if_valid),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_done  (ls_done),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wr) mem[ram_addr] <= ram_dout;
        ram_din <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_valid === 1'b1) begin
            if (fq.size() == 0) check("if_valid_unexpected", 1, 0);
            else                check("if_data", if_data, fq.pop_front());
        end
        if (ls_done === 1'b1) begin
            if (lq.size() == 0) check("ls_done_unexpected", 1, 0);
            else begin
                logic [32:0] e;
                e = lq.pop_front();
                if (!e[32]) check("ls_rdata", ls_rdata, e[31:0]);
            end
        end
        if (ram_wr === 1'b1) begin
            if (wq.size() == 0) check("ram_wr_unexpected", 1, 0);
            else                check("ram_write", {ram_addr, ram_dout}, wq.pop_front());
        end
    end

    task automatic wait_pulse(input bit is_fetch, input string tag, output int at);
        at = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (is_fetch ? if_valid : ls_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_fetch(input logic [16:0] addr, input logic [31:0] exp);
        int e0, at;
        fq.push_back(exp);
        if_req = 1'b1; if_addr = addr;
        e0 = cyc + 1;
        wait_pulse(1'b1, "fetch", at);
        check("fetch_latency", 64'(at - e0), 5);
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] size, input logic [16:0] addr,
                           input logic [31:0] exp, input bit flush);
        int e0, at, n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        lq.push_back({1'b0, exp});
        ls_req = 1'b1; ls_we = 1'b0; ls_size = size; ls_addr = addr; if_flush = flush;
        e0 = cyc + 1;
        wait_pulse(1'b0, "load", at);
        check("load_latency", 64'(at - e0), 64'(n + 1));
        @(posedge clk); #1 ls_req = 1'b0; if_flush = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] size, input logic [16:0] addr, input logic [31:0] wdata);
        int e0, at, n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) wq.push_back({addr + 17'(i), wdata[8*i +: 8]});
        lq.push_back({1'b1, 32'h0});
        ls_req = 1'b1; ls_we = 1'b1; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        e0 = cyc + 1;
        wait_pulse(1'b0, "store", at);
        check("store_latency", 64'(at - e0), 64'(n));
        @(posedge clk); #1 ls_req = 1'b0; ls_we = 1'b0;
    endtask

    initial begin
        int e0, at;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        {mem[17'h100], mem[17'h101], mem[17'h102], mem[17'h103]} = {8'h13, 8'h00, 8'h00, 8'h00};
        {mem[17'h104], mem[17'h105], mem[17'h106], mem[17'h107]} = {8'h93, 8'h00, 8'h10, 8'h00};
        {mem[17'h110], mem[17'h111], mem[17'h112], mem[17'h113]} = {8'h11, 8'h22, 8'h33, 8'h44};
        {mem[17'h120], mem[17'h121], mem[17'h122], mem[17'h123]} = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        {mem[17'h130], mem[17'h131], mem[17'h132], mem[17'h133]} = {8'h01, 8'h02, 8'h03, 8'h04};
        {mem[17'h140], mem[17'h141], mem[17'h142], mem[17'h143]} = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
        {mem[17'h200], mem[17'h201], mem[17'h202], mem[17'h203]} = {8'h78, 8'h56, 8'h34, 8'h12};
        {mem[17'h300], mem[17'h301], mem[17'h302], mem[17'h303]} = {8'h80, 8'hFF, 8'hFF, 8'hFF};

        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_data", if_data, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_valid_done", {if_valid, ls_done}, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_dout", ram_dout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        do_fetch(17'h100, 32'h0000_0013);

        // Simultaneous requests: load wins, fetch starts right after ls_done.
        fq.push_back(32'h0010_0093);
        lq.push_back({1'b0, 32'h1234_5678});
        if_req = 1'b1; if_addr = 17'h104;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 17'h200;
        e0 = cyc + 1;
        wait_pulse(1'b0, "arb_load", at);
        check("arb_load_latency", 64'(at - e0), 5);
        @(posedge clk); #1 ls_req = 1'b0;
        check("arb_fetch_addr", ram_addr, 17'h104);
        check("arb_fetch_busy", busy, 1);
        wait_pulse(1'b1, "arb_fetch", at);
        check("arb_fetch_latency", 64'(at - e0), 11);
        @(posedge clk); #1 if_req = 1'b0;

        // Flush sampled at E3: fetch of 0x110 dropped, 0x120 fetched instead.
        fq.push_back(32'hDDCC_BBAA);
        if_req = 1'b1; if_addr = 17'h110;
        e0 = cyc + 1;
        repeat (3) @(posedge clk);
        #1 if_flush = 1'b1; if_addr = 17'h120;
        @(posedge clk); #1 if_flush = 1'b0;
        check("flush_abort_busy", busy, 0);
        wait_pulse(1'b1, "flush_fetch", at);
        check("flush_refetch_latency", 64'(at - e0), 9);
        @(posedge clk); #1 if_req = 1'b0;

        // Flush in the last cycle of a fetch suppresses if_valid.
        fq.push_back(32'hC33C_A55A);
        if_req = 1'b1; if_addr = 17'h130;
        e0 = cyc + 1;
        repeat (5) @(posedge clk);
        #1 if_flush = 1'b1; if_addr = 17'h140;
        @(posedge clk); #1 if_flush = 1'b0;
        check("flush_last_no_valid", if_valid, 0);
        check("flush_last_busy", busy, 0);
        wait_pulse(1'b1, "flush_last_fetch", at);
        check("flush_last_latency", 64'(at - e0), 11);
        @(posedge clk); #1 if_req = 1'b0;

        do_load(2'd0, 17'h300, 32'h0000_0080, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_ls_rdata", ls_rdata, 32'h0000_0080);
        check("hold_if_data", if_data, 32'hC33C_A55A);

        do_load(2'd1, 17'h301, 32'h0000_FFFF, 1'b0);
        do_store(2'd1, 17'h1FFFF, 32'hDEAD_BEEF);
        do_load(2'd1, 17'h1FFFF, 32'h0000_BEEF, 1'b0);
        do_store(2'd0, 17'h500, 32'h1234_56A7);
        do_load(2'd3, 17'h200, 32'h1234_5678, 1'b1);
        do_load(2'd0, 17'h500, 32'h0000_00A7, 1'b0);

        // Reset after two bytes of a word store: no more writes, no ls_done.
        wq.push_back({17'h400, 8'h44});
        wq.push_back({17'h401, 8'h33});
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 17'h400; ls_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'b0;
        check("rstmid_ram_wr", ram_wr, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ls_done", ls_done, 0);
        check("rstmid_outputs", {if_data, ls_rdata, ram_addr, ram_dout}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_mem_402", mem[17'h402], 8'h00);

        do_fetch(17'h100, 32'h0000_0013);

        repeat (4) @(posedge clk);
        #1;
        check("fetch_queue_empty", fq.size(), 0);
        check("ls_queue_empty", lq.size(), 0);
        check("write_queue_empty", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 17, RAM byte-address width.
REQ-002 Parameter DATA_W, default 32, instruction/data word width; multiple of 8; NB = DATA_W/8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  fetch request; held high until if_valid or if_flush.
REQ-006 if_addr  in  ADDR_W  fetch byte address; stable while if_req high.
REQ-007 if_flush  in  1  pc changed; abort any fetch in flight.
REQ-008 if_data  out  DATA_W  fetched word, little-endian.
REQ-009 if_valid  out  1  one-cycle pulse, if_data valid.
REQ-010 ls_req  in  1  load/store request; held high until ls_done.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-013 ls_addr  in  ADDR_W  data byte address.
REQ-014 ls_wdata  in  DATA_W  store data, low bytes used.
REQ-015 ls_rdata  out  DATA_W  load data, zero-extended.
REQ-016 ls_done  out  1  one-cycle pulse, access complete.
REQ-017 ram_addr  out  ADDR_W  RAM byte address.
REQ-018 ram_wr  out  1  1 = write ram_dout, 0 = read.
REQ-019 ram_dout  out  8  write byte.
REQ-020 ram_din  in  8  read byte; returns data of the address driven in the previous cycle.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, IF_RD, LS_RD, LS_WR; byte counter cnt 0..NB.
REQ-023 In IDLE, a request SHALL be sampled at edge E0; ls_req takes priority over if_req.
REQ-024 A port SHALL NOT be granted in the cycle its own done/valid pulse is high.
REQ-025 Access length N SHALL be NB for fetch and 1/2/NB bytes per ls_size.
REQ-026 Reads: ram_addr = base+i in the cycle after edge E(i), for i = 0..N-1; byte i is captured from ram_din at edge E(i+2).
REQ-027 Reads: if_valid/ls_done SHALL be high for one cycle after edge E(N+1); FSM SHALL return to IDLE at the same edge.
REQ-028 Writes: ram_wr = 1, ram_addr = base+i and ram_dout = ls_wdata byte i in the cycle after edge E(i).
REQ-029 Writes: ls_done SHALL be high for one cycle after edge E(N).
REQ-030 Address increment SHALL wrap modulo 2^ADDR_W; misaligned addresses SHALL be allowed.
REQ-031 ram_wr SHALL be 0 in every cycle that is not a write-byte cycle.
REQ-032 Load bytes above N-1 SHALL read 0; ls_rdata/if_data SHALL hold their value until the next completion.
REQ-033 if_flush during IF_RD SHALL abort: IDLE at next edge, no if_valid, partial data discarded.
REQ-034 if_flush in the cycle if_valid would rise SHALL suppress it.
REQ-035 if_flush SHALL have no effect in IDLE, LS_RD or LS_WR.
REQ-036 A fetch in flight SHALL NOT be preempted by ls_req; ls_req waits for IDLE.

Reset
REQ-037 rst SHALL force IDLE, cnt = 0, and all outputs to 0 (ram_wr = 0) at the next edge.
REQ-038 rst mid-access SHALL abort it without a done/valid pulse and without further RAM writes.

Structure
REQ-039 A shared package SHALL hold the ls_size encodings and the state enum.
REQ-040 One sub-module, mem_byte_asm, SHALL shift-assemble read bytes into a DATA_W word.
REQ-041 Arbitration, FSM and write lane select SHALL reside in mem_ctrl.

Verification
REQ-042 Fetch at 0x100, RAM = 13 00 00 00 -> if_data 0x00000013; if_valid after edge E5.
REQ-043 Simultaneous if_req and ls_req, load word at 0x200 -> load completes first, fetch starts the cycle after ls_done.
REQ-044 Store half 0xBEEF at 0x1FFFF -> writes EF@0x1FFFF, BE@0x00000; ls_done after edge E2.
REQ-045 if_flush at the edge after E2 of a fetch -> no if_valid; new fetch of the new address returns correct data.
REQ-046 Load byte 0x80 -> ls_rdata 0x00000080.
REQ-047 rst during a store -> no further ram_wr; outputs 0.
